// File: rtl/rd_fifo_burst_drain_pkg.sv
// Shared types and elaboration helpers for the prefetch read-FIFO burst drain.
package rd_fifo_burst_drain_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } burst_state_e;

    function automatic int lane_ratio(input int rd_w, input int out_w);
        return rd_w / out_w;
    endfunction

    function automatic bit lane_ratio_ok(input int rd_w, input int out_w);
        return (out_w > 0) && (rd_w >= out_w) && ((rd_w % out_w) == 0);
    endfunction

    function automatic int lane_cnt_width(input int r);
        return (r <= 1) ? 1 : $clog2(r);
    endfunction

endpackage

// File: rtl/rd_fifo_burst_unpack.sv
// Holds one popped FIFO word and presents it lane by lane, LSB lane first.
import rd_fifo_burst_drain_pkg::*;

module rd_fifo_burst_unpack #(
    parameter int c_OUT_DATA_WIDTH = 8,
    parameter int c_LANES          = 4,
    parameter int c_LCW            = lane_cnt_width(c_LANES)
) (
    input  logic                                  rd_clk,
    input  logic                                  rd_rst,
    input  logic                                  load,
    input  logic [c_LANES*c_OUT_DATA_WIDTH-1:0]   word,
    input  logic                                  advance,
    output logic [c_LCW-1:0]                      lane,
    output logic                                  last_lane,
    output logic [c_OUT_DATA_WIDTH-1:0]           m_data
);

    logic [c_LANES-1:0][c_OUT_DATA_WIDTH-1:0] word_q;

    assign last_lane = (lane == c_LCW'(c_LANES - 1));

    // A reload wins over an advance: it happens exactly when the last lane
    // is accepted and the next word is popped in the same cycle.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            word_q <= '0;
            lane   <= '0;
        end else if (load) begin
            word_q <= word;
            lane   <= '0;
        end else if (advance) begin
            lane <= last_lane ? '0 : lane + c_LCW'(1);
        end
    end

    if (c_LANES == 1) begin : g_single
        assign m_data = word_q[0];
    end else begin : g_multi
        assign m_data = word_q[lane];
    end

endmodule

// File: rtl/rd_fifo_burst_drain.sv
// Pops a requested number of words from a FWFT read FIFO and streams them out
// as narrower lanes on a valid/ready master, with end-of-burst marking.
import rd_fifo_burst_drain_pkg::*;

module rd_fifo_burst_drain #(
    parameter int c_RD_DATA_WIDTH  = 32,
    parameter int c_OUT_DATA_WIDTH = 8,
    parameter int c_LEN_WIDTH      = 12
) (
    input  logic                        rd_clk,
    input  logic                        rd_rst,
    input  logic                        burst_req,
    input  logic [c_LEN_WIDTH-1:0]      burst_len,
    input  logic                        abort,
    output logic                        burst_busy,
    output logic                        burst_done,
    output logic [c_LEN_WIDTH-1:0]      words_left,
    input  logic [c_RD_DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                        fifo_rd_vld,
    output logic                        fifo_rd_en,
    output logic [c_OUT_DATA_WIDTH-1:0] m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_last
);

    localparam int R   = lane_ratio(c_RD_DATA_WIDTH, c_OUT_DATA_WIDTH);
    localparam int LCW = lane_cnt_width(R);

    if (!lane_ratio_ok(c_RD_DATA_WIDTH, c_OUT_DATA_WIDTH)) begin : g_bad_ratio
        $error("rd_fifo_burst_drain: read width must be a multiple of lane width");
    end

    burst_state_e   state;
    logic [LCW-1:0] lane_cnt;
    logic           last_lane;
    logic           beat_acc;
    logic           pop;
    logic           no_words;

    assign no_words = (words_left == '0);
    assign beat_acc = m_valid & m_ready;
    // The refill request in SHIFT is combinational from m_ready so the next
    // word lands in the same edge that retires the last lane: no bubble.
    assign fifo_rd_en = (state == S_FETCH) |
                        ((state == S_SHIFT) & m_ready & last_lane & ~no_words);
    assign pop    = fifo_rd_en & fifo_rd_vld;
    assign m_last = m_valid & (lane_cnt == LCW'(R - 1)) & no_words;

    rd_fifo_burst_unpack #(
        .c_OUT_DATA_WIDTH (c_OUT_DATA_WIDTH),
        .c_LANES          (R),
        .c_LCW            (LCW)
    ) u_unpack (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .load      (pop),
        .word      (fifo_rd_data),
        .advance   (beat_acc),
        .lane      (lane_cnt),
        .last_lane (last_lane),
        .m_data    (m_data)
    );

    // A pop that coincides with abort still counts against words_left.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst)
            words_left <= '0;
        else if ((state == S_IDLE) && burst_req && (burst_len != '0))
            words_left <= burst_len;
        else if (pop)
            words_left <= words_left - c_LEN_WIDTH'(1);
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state      <= S_IDLE;
            burst_busy <= 1'b0;
            burst_done <= 1'b0;
            m_valid    <= 1'b0;
        end else if (abort && (state != S_IDLE)) begin
            state      <= S_IDLE;
            burst_busy <= 1'b0;
            burst_done <= 1'b0;
            m_valid    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (burst_req) begin
                    burst_busy <= 1'b1;
                    if (burst_len != '0) begin
                        state <= S_FETCH;
                    end else begin
                        state      <= S_DONE;
                        burst_done <= 1'b1;
                    end
                end
                S_FETCH: if (pop) begin
                    state   <= S_SHIFT;
                    m_valid <= 1'b1;
                end
                S_SHIFT: if (beat_acc && last_lane) begin
                    if (no_words) begin
                        state      <= S_DONE;
                        m_valid    <= 1'b0;
                        burst_done <= 1'b1;
                    end else if (!pop) begin
                        state   <= S_FETCH;
                        m_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    burst_done <= 1'b0;
                    burst_busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rd_fifo_burst_drain.sv
// Bench for rd_fifo_burst_drain: FIFO model, lane scoreboard, table of bursts
// and hand-written abort / mid-burst reset sequences.
module tb_rd_fifo_burst_drain;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic        burst_req;
    logic [11:0] burst_len;
    logic        abort;
    logic        burst_busy;
    logic        burst_done;
    logic [11:0] words_left;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_vld;
    logic        fifo_rd_en;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    rd_fifo_burst_drain #(
        .c_RD_DATA_WIDTH  (32),
        .c_OUT_DATA_WIDTH (8),
        .c_LEN_WIDTH      (12)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .burst_req    (burst_req),
        .burst_len    (burst_len),
        .abort        (abort),
        .burst_busy   (burst_busy),
        .burst_done   (burst_done),
        .words_left   (words_left),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_en   (fifo_rd_en),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last)
    );

    always #5 rd_clk = ~rd_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // FWFT FIFO model
    logic [31:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops   = 0;
    logic flush_req = 1'b0;
    assign fifo_rd_vld  = (rd_ptr != wr_ptr);
    assign fifo_rd_data = mem[rd_ptr % 64];

    always @(posedge rd_clk) begin
        if (flush_req)
            rd_ptr <= wr_ptr;
        else if (fifo_rd_en && fifo_rd_vld) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    task automatic push_words(input logic [31:0] w [4], input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 64] = w[i];
            wr_ptr = wr_ptr + 1;
        end
    endtask

    // sink ready: mode 0 always ready, mode 1 toggles each cycle
    int rdy_mode = 0;
    always @(posedge rd_clk) begin
        #1;
        if (rdy_mode == 1) m_ready = ~m_ready;
        else               m_ready = 1'b1;
    end

    int cyc = 0;
    always @(posedge rd_clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] d; logic last; } beat_t;
    beat_t exp_q [$];

    int   beats = 0, dones = 0, en_cnt = 0, done_cyc = 0, last_cyc = 0;
    int   beat_cyc [4096];
    logic prev_v = 1'b0, prev_r = 1'b0, prev_done = 1'b0;
    logic [7:0] prev_d = '0;

    always @(negedge rd_clk) begin
        if (!rd_rst) begin
            if (fifo_rd_en) en_cnt++;
            if (burst_done) begin dones++; done_cyc = cyc; end
            if (prev_done) chk("busy_fall", burst_busy, 0);
            if (prev_v && !prev_r && m_valid) chk("stall_hold", m_data, prev_d);
            if (m_valid && m_ready) begin
                beat_t e;
                beat_cyc[beats % 4096] = cyc;
                beats++;
                if (m_last) last_cyc = cyc;
                if (exp_q.size() == 0) chk("extra_beat", m_data, 64'hDEAD);
                else begin
                    e = exp_q.pop_front();
                    chk("lane_data", m_data, e.d);
                    chk("lane_last", m_last, e.last);
                end
            end
        end
        prev_v    = m_valid & ~rd_rst;
        prev_r    = m_ready;
        prev_d    = m_data;
        prev_done = burst_done & ~rd_rst;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, burst_busy, 0);
        chk({tag, "_done"}, burst_done, 0);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_words_left"}, words_left, 0);
    endtask

    // Starts at posedge+1, returns at posedge+1.
    task automatic run_burst(input int len, input int mode, input int empty_cyc, input bit push,
                             input logic [31:0] w [4], input int exp_pops, input int exp_beats);
        int p0, b0, d0, e0, rc;
        rdy_mode = mode;
        if (push && empty_cyc == 0) push_words(w, len);
        for (int i = 0; i < len; i++)
            for (int j = 0; j < 4; j++)
                exp_q.push_back('{w[i][8*j +: 8], (i == len - 1) && (j == 3)});
        p0 = pops; b0 = beats; d0 = dones; e0 = en_cnt; rc = cyc;
        burst_req = 1'b1;
        burst_len = 12'(len);
        @(posedge rd_clk); #1;
        burst_req = 1'b0;
        @(negedge rd_clk);
        if (len == 0) chk("zero_len_done", burst_done, 1);
        else          chk("rd_en_T1", fifo_rd_en, 1);
        if (len > 0) begin
            @(negedge rd_clk);
            chk("valid_T2", m_valid, (empty_cyc == 0));
            if (empty_cyc > 0) begin
                for (int k = 0; k < empty_cyc - 1; k++) begin
                    @(negedge rd_clk);
                    chk("fetch_wait_valid", m_valid, 0);
                end
                chk("fetch_wait_busy", burst_busy, 1);
                push_words(w, len);
            end
        end
        for (int i = 0; i < 4000 && dones == d0; i++) @(negedge rd_clk);
        chk("done_seen", dones - d0, 1);
        @(negedge rd_clk);
        repeat (2) @(posedge rd_clk);
        #1;
        chk("pops", pops - p0, exp_pops);
        chk("beats", beats - b0, exp_beats);
        chk("sb_empty", exp_q.size(), 0);
        if (len == 0) begin
            chk("zero_len_T1", done_cyc - rc, 1);
            chk("zero_len_no_rd_en", en_cnt - e0, 0);
        end else begin
            chk("done_after_last", done_cyc - last_cyc, 1);
            if (mode == 0 && empty_cyc == 0)
                chk("no_gap", beat_cyc[(beats - 1) % 4096] - beat_cyc[b0 % 4096], exp_beats - 1);
        end
    endtask

    typedef struct {
        int len; int mode; int empty_cyc; bit fixed;
        int exp_pops; int exp_beats;
    } vec_t;

    initial begin
        vec_t        tbl [6];
        logic [31:0] fixed_w [4];
        logic [31:0] w [4];
        int          p0, b0, d0;

        tbl[0] = '{3, 0, 0, 1'b1, 3, 12};
        tbl[1] = '{3, 1, 0, 1'b1, 3, 12};
        tbl[2] = '{3, 0, 5, 1'b1, 3, 12};
        tbl[3] = '{0, 0, 0, 1'b0, 0, 0};
        tbl[4] = '{1, 1, 0, 1'b0, 1, 4};
        tbl[5] = '{4, 0, 0, 1'b0, 4, 16};
        fixed_w[0] = 32'h44332211;
        fixed_w[1] = 32'h88776655;
        fixed_w[2] = 32'hCCBBAA99;
        fixed_w[3] = 32'h00000000;

        rd_rst = 1'b1; burst_req = 1'b0; burst_len = '0; abort = 1'b0; m_ready = 1'b1;
        repeat (2) @(negedge rd_clk);
        chk_reset_vals("reset");
        @(posedge rd_clk); #1;
        rd_rst = 1'b0;
        repeat (2) @(posedge rd_clk); #1;

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) w[i] = tbl[v].fixed ? fixed_w[i] : $urandom;
            run_burst(tbl[v].len, tbl[v].mode, tbl[v].empty_cyc, 1'b1, w,
                      tbl[v].exp_pops, tbl[v].exp_beats);
        end

        // abort on the 6th beat of a 4-word burst
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        push_words(w, 4);
        for (int j = 0; j < 6; j++) exp_q.push_back('{w[j / 4][8*(j % 4) +: 8], 1'b0});
        p0 = pops; b0 = beats; d0 = dones;
        burst_req = 1'b1; burst_len = 12'd4;
        @(posedge rd_clk); #1;
        burst_req = 1'b0;
        for (int i = 0; i < 200 && (beats - b0) != 5; i++) begin
            @(posedge rd_clk); #1;
        end
        chk("abort_reach_beat6", beats - b0, 5);
        abort = 1'b1;
        @(posedge rd_clk); #1;
        abort = 1'b0;
        @(negedge rd_clk);
        chk("abort_valid_drop", m_valid, 0);
        chk("abort_busy_drop", burst_busy, 0);
        chk("abort_rd_en_drop", fifo_rd_en, 0);
        chk("abort_beats", beats - b0, 6);
        chk("abort_pops", pops - p0, 2);
        chk("abort_fifo_left", wr_ptr - rd_ptr, 2);
        chk("abort_no_done", dones - d0, 0);
        chk("abort_sb_empty", exp_q.size(), 0);
        @(posedge rd_clk); #1;
        w[0] = w[2]; w[1] = w[3];
        run_burst(2, 0, 0, 1'b0, w, 2, 8);

        // asynchronous reset in the middle of SHIFT
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        push_words(w, 3);
        for (int j = 0; j < 12; j++) exp_q.push_back('{w[j / 4][8*(j % 4) +: 8], j == 11});
        b0 = beats;
        burst_req = 1'b1; burst_len = 12'd3;
        @(posedge rd_clk); #1;
        burst_req = 1'b0;
        for (int i = 0; i < 200 && (beats - b0) < 2; i++) begin
            @(posedge rd_clk); #1;
        end
        chk("rst_mid_shift_valid", m_valid, 1);
        rd_rst = 1'b1;
        #1;
        chk_reset_vals("mid_reset");
        @(posedge rd_clk); #1;
        rd_rst = 1'b0;
        exp_q.delete();
        flush_req = 1'b1;
        @(posedge rd_clk); #1;
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        run_burst(2, 1, 0, 1'b1, w, 2, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rd_fifo_burst_drain.md
# rd_fifo_burst_drain

Read-side consumer for the prefetch read FIFO, clocked on rd_clk. On a burst request it pops exactly the requested number of words through the FIFO's first-word-fall-through valid/enable interface. It serializes each popped word into narrower lanes on a valid/ready master stream, LSB lane first, with end-of-burst marking and a completion pulse.

## Interface
Parameters:
- c_RD_DATA_WIDTH, 32, FIFO read word width; must be an integer multiple of c_OUT_DATA_WIDTH.
- c_OUT_DATA_WIDTH, 8, output lane width; R = c_RD_DATA_WIDTH / c_OUT_DATA_WIDTH, R ≥ 1.
- c_LEN_WIDTH, 12, burst length counter width; maximum burst is 2^c_LEN_WIDTH − 1 words.

Ports:
- rd_clk  in  1  clock; all logic in this domain.
- rd_rst  in  1  reset, asynchronous, active-high.
- burst_req  in  1  start pulse; sampled only in IDLE.
- burst_len  in  c_LEN_WIDTH  words to pop; sampled with burst_req.
- abort  in  1  terminate the current burst.
- burst_busy  out  1  high in any state other than IDLE.
- burst_done  out  1  one-cycle pulse at normal burst completion.
- words_left  out  c_LEN_WIDTH  words not yet popped.
- fifo_rd_data  in  c_RD_DATA_WIDTH  FIFO head word.
- fifo_rd_vld  in  1  FIFO head valid.
- fifo_rd_en  out  1  pop request; a pop occurs when fifo_rd_vld & fifo_rd_en.
- m_data  out  c_OUT_DATA_WIDTH  output lane.
- m_valid  out  1  lane valid.
- m_ready  in  1  sink accept.
- m_last  out  1  final lane of final word.

## Operation
- FSM states: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - burst_req=1 with burst_len≠0: latch burst_len into words_left, go to FETCH.
  - burst_req=1 with burst_len=0: go to DONE; no pops.
- FETCH:
  - fifo_rd_en=1.
  - On pop: load the word into the shift register, clear the lane counter, decrement words_left, go to SHIFT.
  - FIFO empty: remain in FETCH indefinitely; no timeout.
- SHIFT:
  - m_valid=1; m_data is lane lane_cnt, i.e. bits [lane_cnt*c_OUT_DATA_WIDTH +: c_OUT_DATA_WIDTH].
  - On m_valid & m_ready: advance lane_cnt.
  - Last lane accepted and words_left≠0: fifo_rd_en=1 in the same cycle (combinational from m_ready).
    - If a pop occurs, reload the shift register and stay in SHIFT with no bubble.
    - Otherwise go to FETCH.
  - Last lane accepted and words_left=0: go to DONE.
- DONE: burst_done=1 for one cycle, then IDLE.
- m_last = SHIFT & lane_cnt=R−1 & words_left=0.
- burst_req while busy: ignored and not queued.
- abort (any state except IDLE): next state IDLE; m_valid and fifo_rd_en drop next cycle; no burst_done pulse. Dropping m_valid without a handshake is a permitted exception. Unpopped FIFO words remain in the FIFO.
- abort coincident with a pop: the pop completes and the word is discarded.
- R=1: each word is emitted as one beat; the lane counter is held at 0.

## Timing
- Reset values:
  - state IDLE
  - burst_busy 0, burst_done 0, fifo_rd_en 0, m_valid 0, m_last 0
  - m_data 0, words_left 0
- burst_req at cycle T with FIFO non-empty:
  - fifo_rd_en high at T+1 and pop at T+1.
  - m_valid high at T+2.
- Sustained throughput with m_ready=1 and FIFO non-empty: one lane per cycle; R cycles per word with no inter-word gap.
- burst_done asserts the cycle after the m_last handshake.
- burst_busy falls in the cycle after burst_done.
- burst_len=0: burst_done at T+1.
- words_left decrements in the cycle after each pop.
- Reset asserted mid-burst: all outputs return to reset values asynchronously.

## Structure
- Package rd_fifo_burst_drain_pkg:
  - FSM state encoding.
  - Lane ratio R and its check.
  - Lane counter width, max(1, clog2(R)).
- Sub-module rd_fifo_burst_unpack: shift register, lane counter and lane mux. Inputs are load, word and advance; outputs are lane, last_lane and m_data.
- Top level holds the FSM, the words_left counter and the pop/abort logic.

## Test plan
- 32→8, burst_len=3, FIFO preloaded with 0x44332211, 0x88776655, 0xCCBBAA99, m_ready=1:
  - m_data 11,22,…,CC on 12 consecutive beats.
  - m_last on beat 12 only.
  - burst_done one cycle later; exactly 3 pops.
- Same burst with m_ready toggling 1,0:
  - Data order unchanged and m_data held stable while stalled.
  - No extra pops.
- FIFO empty for 5 cycles after burst_req, then filled:
  - FSM stays in FETCH with m_valid=0, then the burst completes normally.
- burst_len=0:
  - burst_done at T+1; fifo_rd_en never asserted.
- abort on the 6th beat of a 4-word burst:
  - m_valid low next cycle, no burst_done.
  - FIFO retains the unpopped words; a new burst_req two cycles later starts cleanly.
- rd_rst asserted mid-SHIFT:
  - All outputs return to reset values immediately.
  - burst_req issued after reset release is accepted.
